// File: rtl/sksa_fault_checker.sv
// sksa_fault_checker: drives a segmented adder, checks each segment, retries and corrects
module sksa_fault_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int RETRY_MAX     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_cin,
    output logic [15:0] adder_a,
    output logic [15:0] adder_b,
    output logic        adder_cin,
    input  logic [15:0] adder_s,
    input  logic        adder_c4,
    input  logic        adder_c8,
    input  logic        adder_c12,
    input  logic        adder_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] res_s,
    output logic        res_cout,
    output logic        res_fault,
    output logic        res_transient,
    output logic [3:0]  seg_mask,
    output logic [3:0]  carry_mask,
    output logic [7:0]  fault_count,
    input  logic        clear_stats
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, RESP} state_t;
    state_t state, state_nx;
    logic [3:0]  settle_cnt;
    logic [1:0]  retry_cnt;
    logic        transient;
    logic [15:0] cap_s;
    logic [4:1]  cap_c;
    logic [4:0]  part [4];
    logic [4:0]  c;
    logic [3:0]  seg_err, car_err;
    logic [16:0] sum;
    logic        mismatch, settle_done, retry, finish;

    assign in_ready    = state == IDLE;
    assign out_valid   = state == RESP;
    assign settle_done = settle_cnt == 4'(SETTLE_CYCLES - 1);
    assign retry       = mismatch && (retry_cnt < 2'(RETRY_MAX));
    assign finish      = state == CHECK && !retry;
    assign sum         = {1'b0, adder_a} + {1'b0, adder_b} + {16'b0, adder_cin};

    // Recompute every segment from its own claimed carry-in and compare with the captured outputs
    always_comb begin
        c = {cap_c, adder_cin};
        for (int k = 0; k < 4; k++) begin
            part[k]    = {1'b0, adder_a[4*k +: 4]} + {1'b0, adder_b[4*k +: 4]} + {4'b0, c[k]};
            seg_err[k] = part[k][3:0] != cap_s[4*k +: 4];
            car_err[k] = part[k][4] != c[k+1];
        end
        mismatch = |{seg_err, car_err};
    end

    // Next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? DRIVE : IDLE;
            DRIVE:   state_nx = settle_done ? CHECK : DRIVE;
            CHECK:   state_nx = retry ? DRIVE : RESP;
            default: state_nx = out_ready ? IDLE : RESP;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Operand latch, settle timing, capture, retry bookkeeping and corrected result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adder_a       <= '0;
            adder_b       <= '0;
            adder_cin     <= 1'b0;
            settle_cnt    <= '0;
            retry_cnt     <= '0;
            transient     <= 1'b0;
            cap_s         <= '0;
            cap_c         <= '0;
            res_s         <= '0;
            res_cout      <= 1'b0;
            res_fault     <= 1'b0;
            res_transient <= 1'b0;
        end else begin
            settle_cnt <= (state == DRIVE && !settle_done) ? settle_cnt + 4'd1 : 4'd0;
            if (state == IDLE && in_valid) begin
                adder_a   <= in_a;
                adder_b   <= in_b;
                adder_cin <= in_cin;
                retry_cnt <= '0;
                transient <= 1'b0;
            end
            if (state == DRIVE && settle_done) begin
                cap_s <= adder_s;
                cap_c <= {adder_cout, adder_c12, adder_c8, adder_c4};
            end
            if (state == CHECK && retry) begin
                transient <= 1'b1;
                retry_cnt <= retry_cnt + 2'd1;
            end
            if (finish) begin
                res_s         <= sum[15:0];
                res_cout      <= sum[16];
                res_fault     <= mismatch;
                res_transient <= transient && !mismatch;
            end
        end
    end

    // Sticky localisation masks and saturating permanent-fault count; clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_mask    <= '0;
            carry_mask  <= '0;
            fault_count <= '0;
        end else if (clear_stats) begin
            seg_mask    <= '0;
            carry_mask  <= '0;
            fault_count <= '0;
        end else if (finish && mismatch) begin
            seg_mask    <= seg_mask | seg_err;
            carry_mask  <= carry_mask | car_err;
            fault_count <= (fault_count == 8'hFF) ? fault_count : fault_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_sksa_fault_checker.sv
// tb_sksa_fault_checker: directed checks of the fault checker against a behavioural model
module tb_sksa_fault_checker;
    logic        clk = 0, rst_n = 0, in_valid = 0, in_cin = 0, out_ready = 0, clear_stats = 0;
    logic [15:0] in_a = 0, in_b = 0;
    logic        in_ready, out_valid, adder_cin, res_cout, res_fault, res_transient;
    logic [15:0] adder_a, adder_b, adder_s, res_s;
    logic        adder_c4, adder_c8, adder_c12, adder_cout;
    logic [3:0]  seg_mask, carry_mask;
    logic [7:0]  fault_count;

    sksa_fault_checker dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_s(adder_s), .adder_c4(adder_c4), .adder_c8(adder_c8),
        .adder_c12(adder_c12), .adder_cout(adder_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_s(res_s), .res_cout(res_cout), .res_fault(res_fault), .res_transient(res_transient),
        .seg_mask(seg_mask), .carry_mask(carry_mask), .fault_count(fault_count),
        .clear_stats(clear_stats)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int fmode = 0;
    logic inject = 0, busy = 0;
    logic [15:0] exp_s;
    logic exp_cout, exp_fault, exp_trans;
    logic [3:0] exp_seg = 0, exp_car = 0;
    int exp_cnt = 0;
    logic [15:0] got_s;
    logic got_cout, got_fault, got_trans;
    int got_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Adder under test: mode 0 good, 1 segment 2 reads b[7:4], 2 carry8 stuck 0, 3 sum bit 0 flipped
    function automatic logic [19:0] adder_fn(input logic [15:0] a, b, input logic cin, input int mode);
        logic [15:0] s;
        logic [3:0]  cs, bk;
        logic [4:0]  t;
        logic        cc;
        cc = cin;
        for (int k = 0; k < 4; k++) begin
            bk = (mode == 1 && k == 2) ? b[7:4] : b[4*k +: 4];
            t = {1'b0, a[4*k +: 4]} + {1'b0, bk} + {4'b0, cc};
            s[4*k +: 4] = t[3:0];
            cc = (mode == 2 && k == 1) ? 1'b0 : t[4];
            cs[k] = cc;
        end
        if (mode == 3) s[0] = ~s[0];
        return {cs, s};
    endfunction

    // Segment rule on plain integers: {carry errors, sum errors}
    function automatic logic [7:0] errs(input logic [15:0] a, b, input logic cin, input logic [19:0] o);
        logic [7:0] e;
        int cl [5];
        int v;
        cl[0] = int'(cin);
        for (int k = 0; k < 4; k++) cl[k+1] = int'(o[16+k]);
        for (int k = 0; k < 4; k++) begin
            v = ((int'(a) >> (4*k)) & 15) + ((int'(b) >> (4*k)) & 15) + cl[k];
            e[k]   = (v % 16) != ((int'(o[15:0]) >> (4*k)) & 15);
            e[4+k] = (v / 16) != cl[k+1];
        end
        return e;
    endfunction

    logic [19:0] aout;
    always_comb aout = adder_fn(adder_a, adder_b, adder_cin, (fmode == 3 && !inject) ? 0 : fmode);
    assign {adder_cout, adder_c12, adder_c8, adder_c4, adder_s} = aout;

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, !busy);
            if (out_valid) begin
                chk("res_s", res_s, exp_s);
                chk("res_cout", res_cout, exp_cout);
                chk("res_fault", res_fault, exp_fault);
                chk("res_transient", res_transient, exp_trans);
                chk("seg_mask", seg_mask, exp_seg);
                chk("carry_mask", carry_mask, exp_car);
                chk("fault_count", fault_count, exp_cnt);
            end
        end
    end

    task automatic run(input logic [15:0] a, b, input logic cin, input int mode, input int hold, input string tag);
        logic [19:0] o1, o2;
        logic [7:0] e1, e;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; fmode = mode; inject = (mode == 3); in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        busy = 1;
        o1 = adder_fn(a, b, cin, mode);
        e1 = errs(a, b, cin, o1);
        o2 = (e1 != 0) ? adder_fn(a, b, cin, mode == 3 ? 0 : mode) : o1;
        e  = errs(a, b, cin, o2);
        {exp_cout, exp_s} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        exp_fault = e != 0;
        exp_trans = (e1 != 0) && (e == 0);
        if (exp_fault) begin
            exp_seg |= e[3:0];
            exp_car |= e[7:4];
            if (exp_cnt < 255) exp_cnt++;
        end
        got_lat = 0;
        while (!out_valid && got_lat < 20) begin
            @(posedge clk);
            #1 got_lat++;
            if (got_lat == 1) inject = 0;
        end
        chk({tag, " latency"}, got_lat, (e1 != 0) ? 4 : 2);
        got_s = res_s; got_cout = res_cout; got_fault = res_fault; got_trans = res_transient;
        repeat (hold) @(posedge clk);
        #1 out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        busy = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst adder", {adder_a, adder_b, 15'b0, adder_cin}, 0);
        chk("rst res", {res_s, res_cout, res_fault, res_transient}, 0);
        chk("rst stats", {seg_mask, carry_mask, fault_count}, 0);
        rst_n = 1;

        run(16'h1234, 16'h4321, 0, 0, 0, "basic");
        chk("basic s", got_s, 16'h5555);
        chk("basic cout/fault", {got_cout, got_fault}, 2'b00);

        run(16'hFFFF, 16'h0001, 0, 0, 0, "wrap");
        chk("wrap s", got_s, 16'h0000);
        chk("wrap cout/fault", {got_cout, got_fault}, 2'b10);
        chk("wrap masks", {seg_mask, carry_mask}, 8'h00);

        run(16'h0000, 16'h0F00, 0, 1, 0, "seg2");
        chk("seg2 s", got_s, 16'h0F00);
        chk("seg2 fault", got_fault, 1);
        chk("seg2 masks", {seg_mask, carry_mask}, 8'b0100_0000);
        chk("seg2 count", fault_count, 1);
        chk("seg2 lat", got_lat, 4);

        run(16'h1234, 16'h1111, 0, 3, 0, "trans");
        chk("trans flags", {got_trans, got_fault}, 2'b10);
        chk("trans stats", {seg_mask, carry_mask, fault_count}, {8'b0100_0000, 8'd1});
        chk("trans lat", got_lat, 4);

        run(16'hAAAA, 16'h5555, 1, 0, 5, "hold");
        chk("hold s", {got_cout, got_s}, 17'h10000);

        @(negedge clk) clear_stats = 1;
        @(posedge clk);
        #1 clear_stats = 0;
        exp_seg = 0; exp_car = 0; exp_cnt = 0;
        chk("clear stats", {seg_mask, carry_mask, fault_count}, 0);

        run(16'h00FF, 16'h0001, 0, 2, 0, "c8");
        chk("c8 carry_mask", carry_mask, 4'b0010);
        chk("c8 s", got_s, 16'h0100);
        chk("c8 fault", got_fault, 1);
        for (int i = 0; i < 299; i++) run(16'h00FF, 16'h0001, 0, 2, 0, "c8rep");
        chk("c8 saturate", fault_count, 255);

        @(negedge clk);
        in_a = 16'h1357; in_b = 16'h2468; fmode = 0; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst mid out_valid", out_valid, 0);
        chk("rst mid adder", {adder_a, adder_b}, 0);
        chk("rst mid stats", {seg_mask, carry_mask, fault_count}, 0);
        rst_n = 1;
        exp_seg = 0; exp_car = 0; exp_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post rst out_valid", out_valid, 0);
        end
        chk("post rst stats", {seg_mask, carry_mask, fault_count}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
